// File: rtl/sdram_rom_arbiter_if.sv
// SDRAM toggle-handshake port shared by the ROM arbiter.
// The arbiter drives the request side (master); the SDRAM controller answers (slave).
interface sdram_rom_arbiter_if #(
  parameter int AW = 23
);
  logic          port_req;
  logic          port_ack;
  logic [AW-1:0] port_a;
  logic [1:0]    port_ds;
  logic          port_we;
  logic [15:0]   port_d;
  logic [15:0]   port_q;

  modport master (
    output port_req, port_a, port_ds, port_we, port_d,
    input  port_ack, port_q
  );

  modport slave (
    input  port_req, port_a, port_ds, port_we, port_d,
    output port_ack, port_q
  );
endinterface

// File: rtl/sdram_rom_arbiter.sv
// Arbiter sharing one toggle-handshake SDRAM port between the ROM download
// writer, CPU ROM word fetches and sound wave-sample fetches. Each reader
// keeps a one-entry tagged result; a reader is pending while its tag misses.
module sdram_rom_arbiter #(
  parameter int            AW         = 23,
  parameter logic [AW-1:0] WAVE_BASE  = AW'('h13100),
  parameter int            STARVE_MAX = 4
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          dl_download,
  input  logic          dl_wr,
  input  logic [24:0]   dl_addr,
  input  logic [7:0]    dl_data,
  output logic          dl_busy,
  output logic          dl_overrun,
  output logic          rom_loaded,
  input  logic [AW-1:0] cpu_addr,
  output logic [15:0]   cpu_q,
  output logic          cpu_valid,
  input  logic [AW-1:0] wave_addr,
  output logic [15:0]   wave_q,
  output logic          wave_valid,
  sdram_rom_arbiter_if.master port
);

  localparam int            SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_t;
  typedef enum logic [1:0] {OWN_DL, OWN_CPU, OWN_WAVE} owner_t;

  state_t        state;
  owner_t        owner;

  logic          dl_pend;
  logic [24:0]   dl_a_r;
  logic [7:0]    dl_d_r;
  logic          dl_seen;
  logic          dl_download_q;

  logic [AW-1:0] cpu_tag;
  logic          cpu_tag_v;
  logic [AW-1:0] wave_tag;
  logic          wave_tag_v;
  logic [AW-1:0] req_tag;
  logic [SW-1:0] starve_cnt;

  logic          cpu_hit;
  logic          wave_hit;
  logic          cpu_pend;
  logic          wave_pend;
  logic          wave_first;
  logic          grant_dl;
  logic          grant_cpu;
  logic          grant_wave;
  logic          done;
  logic          dl_rise;
  logic [AW-1:0] wave_rd_a;

  // Hit/pending decode and fixed-priority grant with the wave anti-starvation override
  always_comb begin
    cpu_hit    = cpu_tag_v && (cpu_tag == cpu_addr);
    wave_hit   = wave_tag_v && (wave_tag == wave_addr);
    cpu_valid  = cpu_hit;
    wave_valid = wave_hit;
    cpu_pend   = !dl_download && !cpu_hit;
    wave_pend  = !dl_download && !wave_hit;
    wave_first = wave_pend && (starve_cnt == STARVE_LIM);
    dl_busy    = dl_pend || ((state == S_BUSY) && (owner == OWN_DL));
    done       = (port.port_ack == port.port_req);
    dl_rise    = dl_download && !dl_download_q;
    wave_rd_a  = wave_addr + WAVE_BASE;
    grant_dl   = (state == S_IDLE) && dl_pend;
    grant_wave = (state == S_IDLE) && !dl_pend && wave_pend && (!cpu_pend || wave_first);
    grant_cpu  = (state == S_IDLE) && !dl_pend && cpu_pend && !wave_first;
  end

  // Arbiter FSM: issue on grant, retire on ack, drain a request orphaned by reset
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      // port_req keeps its value so an outstanding SDRAM request can be drained
      if (port.port_req != port.port_ack) state <= S_DRAIN;
      else                                state <= S_IDLE;
      owner         <= OWN_CPU;
      port.port_a   <= '0;
      port.port_ds  <= '0;
      port.port_we  <= 1'b0;
      port.port_d   <= '0;
      cpu_q         <= '0;
      wave_q        <= '0;
      cpu_tag_v     <= 1'b0;
      wave_tag_v    <= 1'b0;
      dl_pend       <= 1'b0;
      dl_overrun    <= 1'b0;
      rom_loaded    <= 1'b0;
      dl_seen       <= 1'b0;
      dl_download_q <= 1'b0;
      starve_cnt    <= '0;
    end else begin
      dl_download_q <= dl_download;
      if (dl_download) dl_seen <= 1'b1;

      // single-entry download buffer; a strobe landing on a full buffer overwrites it
      if (grant_dl) dl_pend <= 1'b0;
      if (dl_wr) begin
        dl_a_r  <= dl_addr;
        dl_d_r  <= dl_data;
        dl_pend <= 1'b1;
        if (dl_pend && !grant_dl) dl_overrun <= 1'b1;
      end

      if (dl_rise)                                  rom_loaded <= 1'b0;
      else if (!dl_download && dl_seen && !dl_busy) rom_loaded <= 1'b1;

      if (grant_wave)                                        starve_cnt <= '0;
      else if (grant_cpu && wave_pend && starve_cnt < STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (grant_dl) begin
            port.port_req <= !port.port_req;
            port.port_a   <= AW'(dl_a_r[24:1]);
            port.port_ds  <= {dl_a_r[0], !dl_a_r[0]};
            port.port_d   <= {dl_d_r, dl_d_r};
            port.port_we  <= 1'b1;
            owner         <= OWN_DL;
            state         <= S_BUSY;
          end else if (grant_wave) begin
            port.port_req <= !port.port_req;
            port.port_a   <= wave_rd_a;
            port.port_ds  <= 2'b11;
            port.port_we  <= 1'b0;
            req_tag       <= wave_addr;
            owner         <= OWN_WAVE;
            state         <= S_BUSY;
          end else if (grant_cpu) begin
            port.port_req <= !port.port_req;
            port.port_a   <= cpu_addr;
            port.port_ds  <= 2'b11;
            port.port_we  <= 1'b0;
            req_tag       <= cpu_addr;
            owner         <= OWN_CPU;
            state         <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (done) begin
            if (owner == OWN_CPU) begin
              cpu_q     <= port.port_q;
              cpu_tag   <= req_tag;
              cpu_tag_v <= 1'b1;
            end else if (owner == OWN_WAVE) begin
              wave_q     <= port.port_q;
              wave_tag   <= req_tag;
              wave_tag_v <= 1'b1;
            end
            port.port_we <= 1'b0;
            state        <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // a new download invalidates everything previously fetched
      if (dl_rise) begin
        cpu_tag_v  <= 1'b0;
        wave_tag_v <= 1'b0;
      end
    end
  end

endmodule
